// File: rtl/seg_pkg.sv
// Shared codes, scan states and code sanitising for the 7-segment display path.
package seg_pkg;

  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_DASH  = 5'd17;
  localparam logic [4:0] CODE_MAX   = 5'd17;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    DRIVE
  } scan_state_t;

  // The cathode decoder holds its last pattern on unmapped codes, so map them to blank.
  function automatic logic [4:0] sanitise_code(input logic [4:0] code);
    return (code > CODE_MAX) ? CODE_BLANK : code;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer: counts REFRESH_DIV cycles per slot, strobing dead_done on the last dead
// cycle and slot_done on the last slot cycle; clear holds the count at zero.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic dead_done,
  output logic slot_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign dead_done = (cnt == CNT_W'(DEAD_CYCLES - 1));
  assign slot_done = (cnt == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || slot_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner with dead time between digits and frame-level snapshot.
// Optional blinking of masked digits when SEG_BLINK_EN is defined.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [5*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [4:0]              digit_holder,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_t             state;
  logic [IDX_W-1:0]        idx;
  logic [5*NUM_DIGITS-1:0] snap;
  logic                    dead_done;
  logic                    slot_done;
  logic                    timer_clear;
  logic                    leave_idle;
  logic                    frame_wrap;
  logic                    slot_blank;
  logic [4:0]              cur_code;
  logic [NUM_DIGITS-1:0]   an_sel;

  assign timer_clear = !enable || (state == IDLE);
  assign leave_idle  = enable && (state == IDLE);
  assign frame_wrap  = enable && (state == DRIVE) && slot_done &&
                       (idx == IDX_W'(NUM_DIGITS - 1));

  seg_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (timer_clear),
    .dead_done (dead_done),
    .slot_done (slot_done)
  );

  always_comb begin
    cur_code = CODE_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_code = snap[5*i +: 5];
    end
  end

  always_comb begin
    an_sel      = '1;
    an_sel[idx] = 1'b0;
  end

`ifdef SEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0]       frame_cnt;
  logic                  blink_off;
  logic [NUM_DIGITS-1:0] mask_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
      mask_snap <= '0;
    end else if (leave_idle) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
      mask_snap <= blink_mask;
    end else if (frame_wrap) begin
      mask_snap <= blink_mask;
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_off <= !blink_off;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  assign slot_blank = blink_off && mask_snap[idx];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign slot_blank   = 1'b0;
`endif

  // Outputs are registered alongside the state so an and digit_holder switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      snap         <= {NUM_DIGITS{CODE_BLANK}};
      an           <= '1;
      digit_holder <= CODE_BLANK;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!enable) begin
        state        <= IDLE;
        idx          <= '0;
        an           <= '1;
        digit_holder <= CODE_BLANK;
      end else begin
        case (state)
          IDLE: begin
            state        <= DEAD;
            idx          <= '0;
            snap         <= digits_in;
            frame_start  <= 1'b1;
            an           <= '1;
            digit_holder <= CODE_BLANK;
          end
          DEAD: begin
            if (dead_done) begin
              state <= DRIVE;
              if (!slot_blank) begin
                an           <= an_sel;
                digit_holder <= sanitise_code(cur_code);
              end
            end
          end
          DRIVE: begin
            if (slot_done) begin
              state        <= DEAD;
              an           <= '1;
              digit_holder <= CODE_BLANK;
              if (frame_wrap) begin
                idx         <= '0;
                snap        <= digits_in;
                frame_start <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          default: begin
            state        <= IDLE;
            an           <= '1;
            digit_holder <= CODE_BLANK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with a short slot (8 cycles, 2 dead) and 4 digits.
module tb_seg_scan_mux;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [19:0] digits_in;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [4:0]  digit_holder;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  seg_scan_mux #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .DEAD_CYCLES  (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .digits_in    (digits_in),
    .blink_mask   (blink_mask),
    .an           (an),
    .digit_holder (digit_holder),
    .frame_start  (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_fs(input string tag, input int budget);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!frame_start && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_fs_seen"}, {31'd0, frame_start}, 32'd1);
  endtask

  // Starts on the first cycle of a frame; ends on the first cycle of the following frame.
  task automatic check_frame(input string tag, input logic [19:0] exp_codes,
                             input logic [3:0] blank, input bit chg,
                             input logic [19:0] chg_val);
    logic [3:0] ea;
    logic [4:0] ed;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        ea = 4'hF;
        ed = 5'd16;
        if (k >= 2 && !blank[s]) begin
          ea[s] = 1'b0;
          ed    = exp_codes[5*s +: 5];
        end
        chk($sformatf("%s_s%0d_c%0d", tag, s, k), {22'd0, frame_start, an, digit_holder},
            {22'd0, (s == 0 && k == 0), ea, ed});
        if (chg && s == 2 && k == 3) digits_in = chg_val;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic ok;
    rst_n      = 1'b0;
    enable     = 1'b0;
    digits_in  = {5'd3, 5'd2, 5'd1, 5'd0};
`ifdef SEG_BLINK_EN
    blink_mask = 4'b0000;
`else
    blink_mask = 4'b1111;
`endif
    tick(3);
    chk("reset", {22'd0, frame_start, an, digit_holder}, {22'd0, 1'b0, 4'hF, 5'd16});
    rst_n = 1'b1;
    tick(2);
    chk("idle", {22'd0, frame_start, an, digit_holder}, {22'd0, 1'b0, 4'hF, 5'd16});

    // Basic scan, then a mid-frame change that must wait for the next frame.
    enable = 1'b1;
    wait_fs("s1", 8);
    check_frame("s1", {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 1'b0, 20'd0);
    check_frame("s2a", {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 1'b1, {5'd9, 5'd9, 5'd9, 5'd9});
    check_frame("s2b", {5'd9, 5'd9, 5'd9, 5'd9}, 4'b0000, 1'b1, {5'd3, 5'd17, 5'd25, 5'd0});
    check_frame("s3", {5'd3, 5'd17, 5'd16, 5'd0}, 4'b0000, 1'b0, 20'd0);

    // Drop enable for one cycle during slot 1 drive.
    tick(11);
    chk("s4_drive", {27'd0, an, digit_holder}, {27'd0, 4'b1101, 5'd16});
    enable    = 1'b0;
    digits_in = {5'd3, 5'd2, 5'd1, 5'd0};
    @(negedge clk);
    chk("s4_off", {22'd0, frame_start, an, digit_holder}, {22'd0, 1'b0, 4'hF, 5'd16});
    enable = 1'b1;
    wait_fs("s4", 8);
    check_frame("s4re", {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 1'b0, 20'd0);

    // Asynchronous reset in the middle of a drive window.
    tick(4);
    chk("s5_drive", {27'd0, an, digit_holder}, {27'd0, 4'b1110, 5'd0});
    #2 rst_n = 1'b0;
    #1 chk("s5_async", {22'd0, frame_start, an, digit_holder}, {22'd0, 1'b0, 4'hF, 5'd16});
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 320; c++) begin
      if (c % 8 == 0) digits_in = 20'($urandom);
      @(negedge clk);
      ok = ($countones(~an) <= 1) && (an != 4'hF || digit_holder == 5'd16) &&
           (digit_holder <= 5'd17);
      chk($sformatf("s5_rand_%0d", c), {31'd0, ok}, 32'd1);
    end

`ifdef SEG_BLINK_EN
    // Slot 2 blinks: on for frames 0-1, off for 2-3, back on in frame 4.
    rst_n      = 1'b0;
    digits_in  = {5'd3, 5'd2, 5'd1, 5'd0};
    blink_mask = 4'b0100;
    tick(2);
    rst_n = 1'b1;
    wait_fs("s6", 8);
    check_frame("s6_f0", {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 1'b0, 20'd0);
    check_frame("s6_f1", {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 1'b0, 20'd0);
    check_frame("s6_f2", {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0100, 1'b0, 20'd0);
    check_frame("s6_f3", {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0100, 1'b0, 20'd0);
    check_frame("s6_f4", {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 1'b0, 20'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
